// File: rtl/credit_arbiter.sv
// Round-robin arbiter sharing one registered up/down credit counter among NUM_REQ requesters.
// Define CREDIT_ARB_BYPASS_EN to let a satisfiable requester bypass a blocked head.
module credit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int AMT_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_reinit,
  input  logic [WIDTH-1:0]         cfg_init_value,
  input  logic                     cfg_pause,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*AMT_W-1:0] req_amt,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     rel_valid,
  input  logic [AMT_W-1:0]         rel_amt,
  output logic                     rel_drop,
  output logic                     ovf_err,
  output logic                     cnt_reinit,
  output logic [WIDTH-1:0]         cnt_initial_value,
  output logic                     cnt_incr_valid,
  output logic [AMT_W-1:0]         cnt_incr,
  output logic                     cnt_decr_valid,
  output logic [AMT_W-1:0]         cnt_decr,
  input  logic [WIDTH-1:0]         cnt_value
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [WIDTH:0] POOL_MAX = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] rr_ptr_nxt_s;
  logic             ovf_err_r;
  logic [AMT_W-1:0] amt_s [NUM_REQ];
  logic [PTR_W-1:0] cand_s;
  logic             head_found_s;
  logic [PTR_W-1:0] head_idx_s;
`ifdef CREDIT_ARB_BYPASS_EN
  logic             pick_found_s;
  logic [PTR_W-1:0] pick_idx_s;
`endif
  logic             grant_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic [AMT_W-1:0] grant_amt_s;
  logic [WIDTH:0]   rel_sum_s;
  logic             rel_ovf_s;

  function automatic logic fits(input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] pool);
    return ((WIDTH+1)'(amt) <= {1'b0, pool});
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_amt
    assign amt_s[g] = req_amt[g*AMT_W +: AMT_W];
  end

  // Round-robin search starting after rr_ptr: head is the first valid requester.
  always_comb begin
    head_found_s = 1'b0;
    head_idx_s   = '0;
    cand_s       = '0;
`ifdef CREDIT_ARB_BYPASS_EN
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s       = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      head_idx_s   = (!head_found_s && req_valid[cand_s]) ? cand_s : head_idx_s;
      head_found_s = head_found_s | req_valid[cand_s];
`ifdef CREDIT_ARB_BYPASS_EN
      pick_idx_s   = (!pick_found_s && req_valid[cand_s] && fits(amt_s[cand_s], cnt_value))
                     ? cand_s : pick_idx_s;
      pick_found_s = pick_found_s | (req_valid[cand_s] && fits(amt_s[cand_s], cnt_value));
`endif
    end
  end

  // Grant decision, pointer update and release overflow check.
  always_comb begin
    grant_s      = 1'b0;
    grant_idx_s  = head_idx_s;
    rr_ptr_nxt_s = rr_ptr_r;
    if (state_r == RUN && head_found_s) begin
`ifdef CREDIT_ARB_BYPASS_EN
      grant_s      = pick_found_s;
      grant_idx_s  = pick_idx_s;
      // A bypass grant leaves the pointer so the blocked head stays first in line.
      rr_ptr_nxt_s = (pick_found_s && (pick_idx_s == head_idx_s)) ? head_idx_s : rr_ptr_r;
`else
      grant_s      = fits(amt_s[head_idx_s], cnt_value);
      rr_ptr_nxt_s = grant_s ? head_idx_s : rr_ptr_r;
`endif
    end else begin
      grant_s = 1'b0;
    end
    grant_amt_s = grant_s ? amt_s[grant_idx_s] : '0;
    rel_sum_s   = {1'b0, cnt_value} + (WIDTH+1)'(rel_amt) - (WIDTH+1)'(grant_amt_s);
    rel_ovf_s   = rel_valid && (state_r != LOAD) && (rel_sum_s > POOL_MAX);
  end

  // Next-state logic; reinit outranks pause.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LOAD:    state_nxt_s = cfg_pause ? PAUSE : RUN;
      RUN:     state_nxt_s = cfg_reinit ? LOAD : (cfg_pause ? PAUSE : RUN);
      PAUSE:   state_nxt_s = cfg_reinit ? LOAD : (cfg_pause ? PAUSE : RUN);
      default: state_nxt_s = LOAD;
    endcase
  end

  // Counter-side and requester-side outputs decoded from the current state.
  always_comb begin
    gnt               = '0;
    rel_drop          = 1'b0;
    cnt_reinit        = 1'b0;
    cnt_initial_value = '0;
    cnt_incr_valid    = 1'b0;
    cnt_incr          = '0;
    cnt_decr_valid    = 1'b0;
    cnt_decr          = '0;
    case (state_r)
      LOAD: begin
        cnt_reinit        = 1'b1;
        cnt_initial_value = cfg_init_value;
        rel_drop          = rel_valid;
      end
      RUN, PAUSE: begin
        gnt            = grant_s ? (NUM_REQ'(1) << grant_idx_s) : '0;
        cnt_decr       = grant_amt_s;
        cnt_decr_valid = grant_s && (grant_amt_s != '0);
        rel_drop       = rel_ovf_s;
        cnt_incr_valid = rel_valid && !rel_ovf_s && (rel_amt != '0);
        cnt_incr       = cnt_incr_valid ? rel_amt : '0;
      end
      default: begin
        gnt = '0;
      end
    endcase
  end

  // State, round-robin pointer and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= LOAD;
      rr_ptr_r  <= PTR_W'(NUM_REQ - 1);
      ovf_err_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      if (state_r != LOAD && state_nxt_s == LOAD) begin
        ovf_err_r <= 1'b0;
      end else if (rel_ovf_s) begin
        ovf_err_r <= 1'b1;
      end else begin
        ovf_err_r <= ovf_err_r;
      end
    end
  end

  assign ovf_err = ovf_err_r;

endmodule

// File: tb/tb_credit_arbiter.sv
// Bench for credit_arbiter: a behavioural credit counter closes the loop, expected
// outputs are queued per driven cycle and compared when the DUT responds.
module tb_credit_arbiter;

  logic       clk;
  logic       rst;
  logic       cfg_reinit;
  logic [3:0] cfg_init_value;
  logic       cfg_pause;
  logic [3:0] req_valid;
  logic [7:0] req_amt;
  logic [3:0] gnt;
  logic       rel_valid;
  logic [1:0] rel_amt;
  logic       rel_drop;
  logic       ovf_err;
  logic       cnt_reinit;
  logic [3:0] cnt_initial_value;
  logic       cnt_incr_valid;
  logic [1:0] cnt_incr;
  logic       cnt_decr_valid;
  logic [1:0] cnt_decr;
  logic [3:0] cnt_value;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic       drop;
    logic       reinit;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];

  credit_arbiter #(.NUM_REQ(4), .WIDTH(4), .AMT_W(2)) dut (
    .clk(clk), .rst(rst), .cfg_reinit(cfg_reinit), .cfg_init_value(cfg_init_value),
    .cfg_pause(cfg_pause), .req_valid(req_valid), .req_amt(req_amt), .gnt(gnt),
    .rel_valid(rel_valid), .rel_amt(rel_amt), .rel_drop(rel_drop), .ovf_err(ovf_err),
    .cnt_reinit(cnt_reinit), .cnt_initial_value(cnt_initial_value),
    .cnt_incr_valid(cnt_incr_valid), .cnt_incr(cnt_incr),
    .cnt_decr_valid(cnt_decr_valid), .cnt_decr(cnt_decr), .cnt_value(cnt_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered credit counter the arbiter sits in front of.
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt_value <= 4'd0;
    else if (cnt_reinit) cnt_value <= cnt_initial_value;
    else cnt_value <= cnt_value + (cnt_incr_valid ? {2'b00, cnt_incr} : 4'd0)
                                - (cnt_decr_valid ? {2'b00, cnt_decr} : 4'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, queue its expectation, check outputs at negedge and state after the edge.
  task automatic drive_cycle(input logic [3:0] rv, input logic [7:0] amts, input logic relv,
                             input logic [1:0] rela, input logic pause, input logic reinit,
                             input logic [3:0] e_gnt, input logic e_drop, input logic e_reinit,
                             input logic [3:0] e_cnt, input logic e_ovf);
    exp_t e;
    req_valid  = rv;
    req_amt    = amts;
    rel_valid  = relv;
    rel_amt    = rela;
    cfg_pause  = pause;
    cfg_reinit = reinit;
    sb_q.push_back({e_gnt, e_drop, e_reinit, e_cnt, e_ovf});
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq("gnt", 32'(gnt), 32'(e.gnt));
    check_eq("rel_drop", 32'(rel_drop), 32'(e.drop));
    check_eq("cnt_reinit", 32'(cnt_reinit), 32'(e.reinit));
    @(posedge clk);
    #1;
    check_eq("pool", 32'(cnt_value), 32'(e.cnt));
    check_eq("ovf_err", 32'(ovf_err), 32'(e.ovf));
  endtask

  initial begin
    logic [3:0] g;
    rst = 1'b0; cfg_reinit = 1'b0; cfg_init_value = 4'd9; cfg_pause = 1'b0;
    req_valid = 4'd0; req_amt = 8'd0; rel_valid = 1'b0; rel_amt = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_reinit", 32'(cnt_reinit), 32'd1);
    check_eq("rst_ovf", 32'(ovf_err), 32'd0);
    check_eq("rst_drop", 32'(rel_drop), 32'd0);
    rst = 1'b1;

    // LOAD cycle then first grant of 3 to requester 0
    drive_cycle(4'b0000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd9, 1'b0);
    drive_cycle(4'b0001, 8'h03, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd6, 1'b0);

    // All four requesting one credit: rotation continues after requester 0
    for (int i = 0; i < 5; i++) begin
      g = 4'b0001 << ((i + 1) % 4);
      drive_cycle(4'b1111, 8'h55, 1'b0, 2'd0, 1'b0, 1'b0, g, 1'b0, 1'b0, 4'(5 - i), 1'b0);
    end

    // Fill pool with releases: 1 -> 4,7,10,13 -> 14
    for (int i = 0; i < 4; i++)
      drive_cycle(4'b0000, 8'h00, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'(4 + 3*i), 1'b0);
    drive_cycle(4'b0000, 8'h00, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd14, 1'b0);
    // Overflowing release is dropped and latches ovf_err
    drive_cycle(4'b0000, 8'h00, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd14, 1'b1);
    // Grant 2 and release 2 in one cycle: net zero
    drive_cycle(4'b0100, 8'h20, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'd14, 1'b1);
    // Release to exactly the pool maximum is accepted
    drive_cycle(4'b0000, 8'h00, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd15, 1'b1);
    drive_cycle(4'b1000, 8'hC0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 4'd12, 1'b1);

    // Pause: no grants, release still applied, then rotation resumes from requester 0
    drive_cycle(4'b0000, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd12, 1'b1);
    drive_cycle(4'b1111, 8'h55, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd12, 1'b1);
    drive_cycle(4'b1111, 8'h55, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd14, 1'b1);
    drive_cycle(4'b1111, 8'h55, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd14, 1'b1);
    drive_cycle(4'b1111, 8'h55, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd13, 1'b1);
    drive_cycle(4'b1111, 8'h55, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'd12, 1'b1);
    drive_cycle(4'b1111, 8'h55, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'd11, 1'b1);

    // Reinit to 5: grant still taken in the RUN cycle, LOAD drops a release, ovf cleared
    cfg_init_value = 4'd5;
    drive_cycle(4'b1111, 8'h55, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 4'd10, 1'b0);
    drive_cycle(4'b1111, 8'h55, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd5, 1'b0);
    drive_cycle(4'b1111, 8'h55, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd4, 1'b0);
    // Zero-amount grant leaves the pool untouched
    drive_cycle(4'b0010, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'd4, 1'b0);
    drive_cycle(4'b0100, 8'h20, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'd2, 1'b0);

    // Pool 2: req0 wants 3 (head), req1 wants 1
`ifdef CREDIT_ARB_BYPASS_EN
    drive_cycle(4'b0011, 8'h07, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'd1, 1'b0);
    drive_cycle(4'b0001, 8'h07, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd3, 1'b0);
    drive_cycle(4'b0001, 8'h07, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd0, 1'b0);
`else
    drive_cycle(4'b0011, 8'h07, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd2, 1'b0);
    drive_cycle(4'b0011, 8'h07, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd4, 1'b0);
    drive_cycle(4'b0011, 8'h07, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0);
    drive_cycle(4'b0010, 8'h07, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'd0, 1'b0);
`endif

    // Reset mid-operation with a request pending, then reload to 7 and restart at requester 0
    req_valid = 4'b0001; req_amt = 8'h01; cfg_init_value = 4'd7;
    rst = 1'b0;
    #1;
    check_eq("midrst_gnt", 32'(gnt), 32'd0);
    check_eq("midrst_reinit", 32'(cnt_reinit), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_cycle(4'b0001, 8'h01, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd7, 1'b0);
    drive_cycle(4'b0001, 8'h01, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
